gpio_irq_ctrl: RTL and testbench

GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

---
 rtl/gpio_pkg.sv | 11 +
 rtl/gpio_debounce.sv | 29 ++
 rtl/gpio_irq_ctrl.sv | 67 ++++++
 tb/tb_gpio_irq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and defaults shared by the GPIO interrupt controller
package gpio_pkg;
  localparam int GPIO_WIDTH_DEF = 8;
  typedef enum logic [2:0] {
    REG_IN      = 3'd0,
    REG_MASK    = 3'd1,
    REG_RISE_EN = 3'd2,
    REG_FALL_EN = 3'd3,
    REG_PENDING = 3'd4
  } reg_t;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-pin synchronizer, debounce counter and one-cycle edge flags
module gpio_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0]  sync;
  logic [15:0] cnt;
  logic        done;
  // edges are flagged on the cycle the new level is accepted
  assign done = (sync[1] != level) && (cnt == 16'(DB_CYCLES - 1));
  assign rise = done & sync[1];
  assign fall = done & ~sync[1];
  always_ff @(posedge clk)
    if (rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync  <= {sync[0], pin};
      cnt   <= (sync[1] == level || done) ? '0 : cnt + 16'd1;
      if (done) level <= sync[1];
    end
endmodule

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: debounced GPIO inputs with edge-triggered, maskable interrupt and Wishbone registers
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int GPIO_WIDTH   = GPIO_WIDTH_DEF,
  parameter int DB_CYCLES    = 16,
  parameter int WB_DAT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] wb_dat_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
  output logic                    wb_ack_o,
  input  logic [GPIO_WIDTH-1:0]   gpio_i,
  output logic                    irq
);
  logic [GPIO_WIDTH-1:0] level, rise, fall, mask, rise_en, fall_en, pending, rd, wd, clr;
  logic [2:0]            sel;
  logic                  ack, acc, wr, unused;
  assign sel      = wb_adr_i[4:2];
  assign wd       = wb_dat_i[GPIO_WIDTH-1:0];
  assign acc      = wb_stb_i & wb_cyc_i & ~ack;
  assign wr       = acc & wb_we_i;
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack;
  assign unused   = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[WB_DAT_WIDTH-1:GPIO_WIDTH]};
  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_db
    gpio_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .pin  (gpio_i[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end
  always_comb begin
    rd  = sel == REG_IN      ? level   :
          sel == REG_MASK    ? mask    :
          sel == REG_RISE_EN ? rise_en :
          sel == REG_FALL_EN ? fall_en :
          sel == REG_PENDING ? pending : '0;
    clr = (wr && sel == REG_PENDING) ? wd : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      ack      <= 1'b0;
      wb_dat_o <= '0;
      mask     <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      pending  <= '0;
      irq      <= 1'b0;
    end else begin
      ack     <= acc;
      irq     <= |(pending & mask);
      // a fresh edge overrides a same-cycle write-1-to-clear
      pending <= (pending & ~clr) | (rise & rise_en) | (fall & fall_en);
      if (acc) wb_dat_o <= {{(WB_DAT_WIDTH-GPIO_WIDTH){1'b0}}, rd};
      if (wr && sel == REG_MASK)    mask    <= wd;
      if (wr && sel == REG_RISE_EN) rise_en <= wd;
      if (wr && sel == REG_FALL_EN) fall_en <= wd;
    end
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb_gpio_irq_ctrl: directed and randomized checks of gpio_irq_ctrl against a window-based reference model
module tb_gpio_irq_ctrl;
  localparam int W = 8, DB = 16;
  logic clk = 1'b0, rst = 1'b1, we = 1'b0, cyc = 1'b0, stb = 1'b0, ack, irq;
  logic [31:0] adr = 32'h0, dat_i = 32'h0, dat_o, r;
  logic [W-1:0] gpio = '0;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] m_lvl, m_mask, m_ren, m_fen, m_pend;
  logic m_irq;
  logic [31:0] m_rd;
  logic [W-1:0] ph[$], win[$];
  bit acc_now = 1'b0, rand_pins = 1'b0;
  int hold[W];

  gpio_irq_ctrl #(.GPIO_WIDTH(W), .DB_CYCLES(DB), .WB_DAT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_we_i(we),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .gpio_i(gpio), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0: return m_lvl;
      3'd1: return m_mask;
      3'd2: return m_ren;
      3'd3: return m_fen;
      3'd4: return m_pend;
      default: return '0;
    endcase
  endfunction

  // one clock: the level flips once the delayed pin has disagreed with it for DB straight cycles
  task automatic tick();
    logic [W-1:0] d, flip, set, clr;
    logic [2:0] a;
    @(posedge clk);
    if (rst) begin
      {m_lvl, m_mask, m_ren, m_fen, m_pend} = '0;
      m_irq = 1'b0;
      m_rd = 32'h0;
      ph.delete();
      ph.push_back('0);
      ph.push_back('0);
      win.delete();
    end else begin
      d = ph.pop_front();
      ph.push_back(gpio);
      win.push_back(d);
      if (win.size() > DB) void'(win.pop_front());
      flip = '0;
      if (win.size() == DB)
        for (int b = 0; b < W; b++) begin
          flip[b] = 1'b1;
          foreach (win[k]) if (win[k][b] == m_lvl[b]) flip[b] = 1'b0;
        end
      set = (flip & ~m_lvl & m_ren) | (flip & m_lvl & m_fen);
      m_irq = |(m_pend & m_mask);
      a = adr[4:2];
      clr = '0;
      if (acc_now) begin
        m_rd = 32'(m_reg(a));
        if (we) begin
          if (a == 3'd1) m_mask = dat_i[W-1:0];
          if (a == 3'd2) m_ren = dat_i[W-1:0];
          if (a == 3'd3) m_fen = dat_i[W-1:0];
          if (a == 3'd4) clr = dat_i[W-1:0];
        end
      end
      m_pend = (m_pend & ~clr) | set;
      m_lvl ^= flip;
    end
    #1;
    check("irq", 32'(irq), 32'(m_irq));
    if (rand_pins)
      for (int b = 0; b < W; b++) begin
        hold[b]--;
        if (hold[b] == 0) begin
          gpio[b] = ~gpio[b];
          hold[b] = int'($urandom_range(1, 40));
        end
      end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, output logic [31:0] rdat);
    adr = a;
    we = w;
    dat_i = d;
    stb = 1'b1;
    cyc = 1'b1;
    acc_now = 1'b1;
    tick();
    acc_now = 1'b0;
    check("ack", 32'(ack), 32'h1);
    if (!w) check("rdata", dat_o, m_rd);
    rdat = dat_o;
    stb = 1'b0;
    cyc = 1'b0;
    we = 1'b0;
    tick();
    check("ack_idle", 32'(ack), 32'h0);
  endtask

  initial begin
    for (int b = 0; b < W; b++) hold[b] = 1;
    repeat (3) tick();
    rst = 1'b0;
    for (int a = 0; a < 5; a++) begin
      xfer(32'(a * 4), 1'b0, 32'h0, r);
      check("reset_read", r, 32'h0);
    end
    check("reset_irq", 32'(irq), 32'h0);
    // rising edge on bit 0: level at cycle 18, irq at cycle 19
    xfer(32'h8, 1'b1, 32'h1, r);
    xfer(32'h4, 1'b1, 32'h1, r);
    gpio[0] = 1'b1;
    repeat (18) tick();
    check("rise_irq_c18", 32'(irq), 32'h0);
    tick();
    check("rise_irq_c19", 32'(irq), 32'h1);
    xfer(32'h0, 1'b0, 32'h0, r);
    check("rise_in", r, 32'h1);
    xfer(32'h10, 1'b0, 32'h0, r);
    check("rise_pend", r, 32'h1);
    // write-1-to-clear, then a clear colliding with a new edge
    xfer(32'h10, 1'b1, 32'h1, r);
    check("w1c_irq", 32'(irq), 32'h0);
    xfer(32'h10, 1'b0, 32'h0, r);
    check("w1c_pend", r, 32'h0);
    xfer(32'hC, 1'b1, 32'h1, r);
    gpio[0] = 1'b0;
    repeat (18) tick();
    xfer(32'h10, 1'b0, 32'h0, r);
    check("fall_pend", r, 32'h1);
    gpio[0] = 1'b1;
    repeat (17) tick();
    xfer(32'h10, 1'b1, 32'h1, r);
    xfer(32'h10, 1'b0, 32'h0, r);
    check("set_wins", r, 32'h1);
    // short glitch on bit 3
    xfer(32'h10, 1'b1, 32'hFF, r);
    xfer(32'h8, 1'b1, 32'h09, r);
    xfer(32'hC, 1'b1, 32'h09, r);
    xfer(32'h4, 1'b1, 32'hFF, r);
    gpio[3] = 1'b1;
    repeat (10) tick();
    gpio[3] = 1'b0;
    repeat (30) tick();
    xfer(32'h0, 1'b0, 32'h0, r);
    check("glitch_in", r, 32'h1);
    xfer(32'h10, 1'b0, 32'h0, r);
    check("glitch_pend", r, 32'h0);
    check("glitch_irq", 32'(irq), 32'h0);
    // masked fall on bit 7, then unmask
    xfer(32'h4, 1'b1, 32'h0, r);
    xfer(32'h8, 1'b1, 32'h0, r);
    xfer(32'hC, 1'b1, 32'h80, r);
    gpio[7] = 1'b1;
    repeat (20) tick();
    gpio[7] = 1'b0;
    repeat (20) tick();
    xfer(32'h10, 1'b0, 32'h0, r);
    check("masked_pend", r, 32'h80);
    check("masked_irq", 32'(irq), 32'h0);
    xfer(32'h4, 1'b1, 32'h80, r);
    check("unmask_irq", 32'(irq), 32'h1);
    // held strobe
    adr = 32'h0;
    we = 1'b0;
    stb = 1'b1;
    cyc = 1'b1;
    #1;
    check("hold_ack0", 32'(ack), 32'h0);
    tick();
    check("hold_ack1", 32'(ack), 32'h1);
    tick();
    check("hold_ack2", 32'(ack), 32'h0);
    tick();
    check("hold_ack3", 32'(ack), 32'h1);
    stb = 1'b0;
    cyc = 1'b0;
    tick();
    xfer(32'h18, 1'b0, 32'h0, r);
    check("addr6", r, 32'h0);
    // reset during a transfer with pins held high
    gpio = '1;
    repeat (4) tick();
    stb = 1'b1;
    cyc = 1'b1;
    tick();
    check("pre_rst_ack", 32'(ack), 32'h1);
    rst = 1'b1;
    tick();
    check("rst_ack", 32'(ack), 32'h0);
    adr = 32'h4;
    we = 1'b1;
    dat_i = 32'hFF;
    tick();
    check("rst_ack_wr", 32'(ack), 32'h0);
    stb = 1'b0;
    cyc = 1'b0;
    we = 1'b0;
    rst = 1'b0;
    xfer(32'h0, 1'b0, 32'h0, r);
    check("rst_in", r, 32'h0);
    xfer(32'h4, 1'b0, 32'h0, r);
    check("rst_mask", r, 32'h0);
    xfer(32'h8, 1'b1, 32'hFF, r);
    xfer(32'h4, 1'b1, 32'hFF, r);
    repeat (12) tick();
    xfer(32'h10, 1'b0, 32'h0, r);
    check("post_rst_rise", r, 32'hFF);
    // random pins and bus traffic
    rand_pins = 1'b1;
    for (int n = 0; n < 500; n++)
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 8)) tick();
      else xfer($urandom, 1'($urandom_range(0, 1)), $urandom, r);
    rand_pins = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
